// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter: shares one dual-read register file between requesters A and B.
// Round-robin arbitration in IDLE, latches the winning request, then sequences the
// register file controls (WR for writes, RD+CAP for reads) and returns a one-cycle ACK.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   {a,b}_req_i/_we_i            request (held until grant), 1=write 0=read
//   {a,b}_addr_w_i/_data_w_i     write address / data
//   {a,b}_addr_r1_i/_addr_r2_i   read addresses
//   {a,b}_gnt_o                  combinational accept pulse (operands latched at this edge)
//   {a,b}_ack_o                  registered one-cycle completion pulse
//   rsp_data_r1_o/_r2_o          captured read data, valid with ACK after a read
//   rf_*_o / rf_data_r*_i        register file control and read data
module rf_access_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter bit          ZERO_WR_BLOCK = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_req_i,
    input  logic                  a_we_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_w_i,
    input  logic [DATA_WIDTH-1:0] a_data_w_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_r1_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_r2_i,
    output logic                  a_gnt_o,
    output logic                  a_ack_o,
    input  logic                  b_req_i,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_w_i,
    input  logic [DATA_WIDTH-1:0] b_data_w_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_r1_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_r2_i,
    output logic                  b_gnt_o,
    output logic                  b_ack_o,
    output logic [DATA_WIDTH-1:0] rsp_data_r1_o,
    output logic [DATA_WIDTH-1:0] rsp_data_r2_o,
    output logic                  rf_read_o,
    output logic                  rf_write_o,
    output logic [ADDR_WIDTH-1:0] rf_addr_w_o,
    output logic [ADDR_WIDTH-1:0] rf_addr_r1_o,
    output logic [ADDR_WIDTH-1:0] rf_addr_r2_o,
    output logic [DATA_WIDTH-1:0] rf_data_w_o,
    input  logic [DATA_WIDTH-1:0] rf_data_r1_i,
    input  logic [DATA_WIDTH-1:0] rf_data_r2_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_CAP  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;   // 0: A owns the op, 1: B
    logic                  ptr_q, ptr_d;       // 0: A has priority, 1: B
    logic                  a_ack_q, a_ack_d;
    logic                  b_ack_q, b_ack_d;
    logic [ADDR_WIDTH-1:0] addr_w_q, addr_w_d;
    logic [ADDR_WIDTH-1:0] addr_r1_q, addr_r1_d;
    logic [ADDR_WIDTH-1:0] addr_r2_q, addr_r2_d;
    logic [DATA_WIDTH-1:0] data_w_q, data_w_d;
    logic [DATA_WIDTH-1:0] rsp_r1_q, rsp_r1_d;
    logic [DATA_WIDTH-1:0] rsp_r2_q, rsp_r2_d;
    logic                  grant_a_c, grant_b_c;

    // Next-state, arbitration and operand latching
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        addr_w_d  = addr_w_q;
        addr_r1_d = addr_r1_q;
        addr_r2_d = addr_r2_q;
        data_w_d  = data_w_q;
        rsp_r1_d  = rsp_r1_q;
        rsp_r2_d  = rsp_r2_q;
        grant_a_c = 1'b0;
        grant_b_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Pointer side wins a tie; the winner then drops to lowest priority
                grant_a_c = a_req_i && (!b_req_i || !ptr_q);
                grant_b_c = b_req_i && (!a_req_i ||  ptr_q);
                if (grant_a_c) begin
                    owner_d   = 1'b0;
                    ptr_d     = 1'b1;
                    addr_w_d  = a_addr_w_i;
                    addr_r1_d = a_addr_r1_i;
                    addr_r2_d = a_addr_r2_i;
                    data_w_d  = a_data_w_i;
                    state_d   = a_we_i ? S_WR : S_RD;
                end else if (grant_b_c) begin
                    owner_d   = 1'b1;
                    ptr_d     = 1'b0;
                    addr_w_d  = b_addr_w_i;
                    addr_r1_d = b_addr_r1_i;
                    addr_r2_d = b_addr_r2_i;
                    data_w_d  = b_data_w_i;
                    state_d   = b_we_i ? S_WR : S_RD;
                end
            end
            S_WR: begin
                state_d = S_IDLE;
                a_ack_d = !owner_q;
                b_ack_d =  owner_q;
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                rsp_r1_d = rf_data_r1_i;
                rsp_r2_d = rf_data_r2_i;
                state_d  = S_IDLE;
                a_ack_d  = !owner_q;
                b_ack_d  =  owner_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any op in flight without ACK
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            ptr_q     <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            addr_w_q  <= '0;
            addr_r1_q <= '0;
            addr_r2_q <= '0;
            data_w_q  <= '0;
            rsp_r1_q  <= '0;
            rsp_r2_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            addr_w_q  <= addr_w_d;
            addr_r1_q <= addr_r1_d;
            addr_r2_q <= addr_r2_d;
            data_w_q  <= data_w_d;
            rsp_r1_q  <= rsp_r1_d;
            rsp_r2_q  <= rsp_r2_d;
        end
    end

    // Moore strobes decoded from the state register; write to address 0 optionally suppressed
    assign rf_read_o  = (state_q == S_RD) || (state_q == S_CAP);
    assign rf_write_o = (state_q == S_WR) && !(ZERO_WR_BLOCK && (addr_w_q == '0));

    assign rf_addr_w_o   = addr_w_q;
    assign rf_addr_r1_o  = addr_r1_q;
    assign rf_addr_r2_o  = addr_r2_q;
    assign rf_data_w_o   = data_w_q;
    assign rsp_data_r1_o = rsp_r1_q;
    assign rsp_data_r2_o = rsp_r2_q;
    assign a_gnt_o       = grant_a_c;
    assign b_gnt_o       = grant_b_c;
    assign a_ack_o       = a_ack_q;
    assign b_ack_o       = b_ack_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Testbench for rf_access_arbiter: behavioural register file behind the DUT, plus a
// transaction-level reference (expected register contents, expected response data,
// round-robin winner) that every DUT observation is compared with.
module tb_rf_access_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr_w, a_addr_r1, a_addr_r2, b_addr_w, b_addr_r1, b_addr_r2;
    logic [DW-1:0] a_data_w, b_data_w;
    logic          a_gnt, a_ack, b_gnt, b_ack;
    logic [DW-1:0] rsp1, rsp2, rf_data_w, rf_data_r1, rf_data_r2;
    logic          rf_read, rf_write;
    logic [AW-1:0] rf_addr_w, rf_addr_r1, rf_addr_r2;

    logic [DW-1:0] rf_mem [32];
    logic          rf_clear;

    logic [DW-1:0] exp_mem [32];
    logic [DW-1:0] exp_rsp1, exp_rsp2;
    int            n_tests = 0;
    int            n_fail  = 0;

    rf_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_WR_BLOCK(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_w_i(a_addr_w), .a_data_w_i(a_data_w),
        .a_addr_r1_i(a_addr_r1), .a_addr_r2_i(a_addr_r2), .a_gnt_o(a_gnt), .a_ack_o(a_ack),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_w_i(b_addr_w), .b_data_w_i(b_data_w),
        .b_addr_r1_i(b_addr_r1), .b_addr_r2_i(b_addr_r2), .b_gnt_o(b_gnt), .b_ack_o(b_ack),
        .rsp_data_r1_o(rsp1), .rsp_data_r2_o(rsp2),
        .rf_read_o(rf_read), .rf_write_o(rf_write),
        .rf_addr_w_o(rf_addr_w), .rf_addr_r1_o(rf_addr_r1), .rf_addr_r2_o(rf_addr_r2),
        .rf_data_w_o(rf_data_w), .rf_data_r1_i(rf_data_r1), .rf_data_r2_i(rf_data_r2)
    );

    always #5 clk = ~clk;

    // Plain storage array standing in for the register file (address 0 is writable here)
    assign rf_data_r1 = rf_mem[rf_addr_r1];
    assign rf_data_r2 = rf_mem[rf_addr_r2];
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
        end else if (rf_write) begin
            rf_mem[rf_addr_w] <= rf_data_w;
        end
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    function automatic logic gnt_of(input bit s);
        return s ? b_gnt : a_gnt;
    endfunction

    function automatic logic ack_of(input bit s);
        return s ? b_ack : a_ack;
    endfunction

    task automatic drive(input bit s, input logic req, input logic we, input logic [AW-1:0] aw,
                         input logic [DW-1:0] dw, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        if (s) begin
            b_req = req; b_we = we; b_addr_w = aw; b_data_w = dw; b_addr_r1 = r1; b_addr_r2 = r2;
        end else begin
            a_req = req; a_we = we; a_addr_w = aw; a_data_w = dw; a_addr_r1 = r1; a_addr_r2 = r2;
        end
    endtask

    // Reference: writes to 0 are dropped, reads return current contents
    task automatic model_apply(input logic we, input logic [AW-1:0] aw, input logic [DW-1:0] dw,
                               input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        if (we) begin
            if (aw != '0) exp_mem[aw] = dw;
        end else begin
            exp_rsp1 = exp_mem[r1];
            exp_rsp2 = exp_mem[r2];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rsp1 = '0;
        exp_rsp2 = '0;
    endtask

    // One complete single-requester transaction, checked cycle by cycle
    task automatic do_op(input bit s, input logic we, input logic [AW-1:0] aw, input logic [DW-1:0] dw,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        int wait_c;
        int lat;
        @(negedge clk);
        drive(s, 1'b1, we, aw, dw, r1, r2);
        #1;
        wait_c = 0;
        while (gnt_of(s) !== 1'b1 && wait_c < 20) begin
            @(negedge clk); #1; wait_c++;
        end
        check1("op_gnt", gnt_of(s), 1'b1);
        check1("op_gnt_other", gnt_of(!s), 1'b0);
        @(negedge clk);
        drive(s, 1'b0, we, aw, dw, r1, r2);
        #1;
        if (we) begin
            check1("wr_strobe", rf_write, (aw != '0));
            check1("wr_no_read", rf_read, 1'b0);
            check32("wr_addr", 32'(rf_addr_w), 32'(aw));
            check32("wr_data", rf_data_w, dw);
        end else begin
            check1("rd_strobe", rf_read, 1'b1);
            check1("rd_no_write", rf_write, 1'b0);
            check32("rd_addr1", 32'(rf_addr_r1), 32'(r1));
            check32("rd_addr2", 32'(rf_addr_r2), 32'(r2));
        end
        model_apply(we, aw, dw, r1, r2);
        lat = 1;
        while (ack_of(s) !== 1'b1 && lat < 8) begin
            @(negedge clk); #1; lat++;
        end
        check32("ack_latency", 32'(lat), we ? 32'd2 : 32'd3);
        check1("ack_other", ack_of(!s), 1'b0);
        check32("rsp_r1", rsp1, exp_rsp1);
        check32("rsp_r2", rsp2, exp_rsp2);
        @(negedge clk); #1;
        check1("ack_pulse", ack_of(s), 1'b0);
    endtask

    initial begin
        int  k;
        int  cyc;
        int  gcyc [4];
        bit  got;
        bit  w;
        bit  mptr;
        bit  pend_owner;

        for (int i = 0; i < 32; i++) exp_mem[i] = '0;
        exp_rsp1 = '0;
        exp_rsp2 = '0;
        rst      = 1'b1;
        rf_clear = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        rf_clear = 1'b0;
        #1;
        // Reset state
        check1("rst_rf_read", rf_read, 1'b0);
        check1("rst_rf_write", rf_write, 1'b0);
        check32("rst_addr_w", 32'(rf_addr_w), 32'd0);
        check32("rst_addr_r1", 32'(rf_addr_r1), 32'd0);
        check32("rst_addr_r2", 32'(rf_addr_r2), 32'd0);
        check32("rst_data_w", rf_data_w, 32'd0);
        check32("rst_rsp1", rsp1, 32'd0);
        check32("rst_rsp2", rsp2, 32'd0);
        check1("rst_a_ack", a_ack, 1'b0);
        check1("rst_b_ack", b_ack, 1'b0);
        check1("rst_a_gnt", a_gnt, 1'b0);

        // Basic write then read back through the other requester
        do_op(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, '0, '0);
        do_op(1'b1, 1'b0, '0, '0, 5'd5, 5'd0);
        check32("basic_rd_r1", rsp1, 32'hDEADBEEF);
        check32("basic_rd_r2", rsp2, 32'h0);

        // Write to address 0 is blocked but acknowledged
        do_op(1'b0, 1'b1, 5'd0, 32'h1234, '0, '0);
        do_op(1'b0, 1'b0, '0, '0, 5'd0, 5'd5);
        check32("zero_rd_r1", rsp1, 32'h0);

        // Back-to-back writes with request held: one grant every 2 cycles
        k = 0; cyc = 0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 5'd1, 32'hB2B00001, '0, '0);
        while (k < 4 && cyc < 40) begin
            #1;
            got = a_gnt;
            if (got) begin
                gcyc[k] = cyc;
                model_apply(1'b1, AW'(k + 1), 32'hB2B00000 + 32'(k + 1), '0, '0);
                k++;
            end
            @(negedge clk);
            cyc++;
            if (got) begin
                if (k < 4) drive(1'b0, 1'b1, 1'b1, AW'(k + 1), 32'hB2B00000 + 32'(k + 1), '0, '0);
                else       drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        check32("b2b_grants", 32'(k), 32'd4);
        for (int i = 0; i < 3; i++) check32("b2b_interval", 32'(gcyc[i + 1] - gcyc[i]), 32'd2);
        repeat (3) @(negedge clk);
        do_op(1'b1, 1'b0, '0, '0, 5'd1, 5'd2);
        do_op(1'b0, 1'b0, '0, '0, 5'd3, 5'd4);
        check32("b2b_rd4", rsp2, 32'hB2B00004);

        // Contention from reset: both hold requests for four ops
        do_reset();
        mptr = 1'b0; pend_owner = 1'b0; k = 0;
        drive(1'b0, 1'b1, 1'b1, 5'd10, 32'hAAAA0010, '0, '0);
        drive(1'b1, 1'b1, 1'b1, 5'd11, 32'hBBBB0011, '0, '0);
        for (int c = 0; c < 14; c++) begin
            #1;
            check1("cont_one_gnt", a_gnt && b_gnt, 1'b0);
            check1("cont_one_ack", a_ack && b_ack, 1'b0);
            if (a_ack || b_ack) check1("cont_ack_owner", b_ack, pend_owner);
            got = a_gnt || b_gnt;
            if (got) begin
                w = b_gnt;
                check1("cont_winner", w, mptr);
                check1("cont_order", w, 1'(k % 2));
                mptr = !w;
                pend_owner = w;
                model_apply(1'b1, w ? 5'd11 : 5'd10, w ? 32'hBBBB0011 : 32'hAAAA0010, '0, '0);
                k++;
            end
            @(negedge clk);
            if (got && k >= 4) begin
                drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
                drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
            end
        end
        check32("cont_grants", 32'(k), 32'd4);
        do_op(1'b1, 1'b0, '0, '0, 5'd10, 5'd11);

        // Reset in RD: abort, no ACK, response cleared, pointer back to A
        do_op(1'b0, 1'b1, 5'd12, 32'h0C0C0C0C, '0, '0);
        do_op(1'b1, 1'b1, 5'd13, 32'h0D0D0D0D, '0, '0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, '0, '0, 5'd5, 5'd10);
        #1;
        check1("mid_gnt", a_gnt, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 5'd5, 5'd10);
        #1;
        check1("mid_in_rd", rf_read, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rsp1 = '0;
        exp_rsp2 = '0;
        #1;
        check1("mid_rf_read", rf_read, 1'b0);
        check1("mid_rf_write", rf_write, 1'b0);
        check32("mid_rsp1", rsp1, 32'd0);
        check32("mid_rsp2", rsp2, 32'd0);
        check32("mid_addr_r1", 32'(rf_addr_r1), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check1("mid_no_ack", a_ack || b_ack, 1'b0);
            @(negedge clk); #1;
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, '0, '0, 5'd5, 5'd5);
        drive(1'b1, 1'b1, 1'b0, '0, '0, 5'd5, 5'd5);
        #1;
        check1("mid_ptr_a", a_gnt, 1'b1);
        check1("mid_ptr_b", b_gnt, 1'b0);
        model_apply(1'b0, '0, '0, 5'd5, 5'd5);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        repeat (4) @(negedge clk);
        #1;
        check32("mid_after_rsp1", rsp1, exp_rsp1);

        // Randomised single-requester traffic against the reference
        for (int i = 0; i < 24; i++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                  $urandom, AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
